// File: rtl/mem_cmd_pkg.sv
// Shared definitions for the memory command parser.
//   state_e   : parser FSM states
//   *_BIT     : command byte field positions (write, read, burst)
//   BURST_LEN : beats per burst command when MEM_CMD_BURST_EN is defined
package mem_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StRdIssue,
    StRdWait,
    StRsp
  } state_e;

  localparam int unsigned WR_BIT    = 7;
  localparam int unsigned RD_BIT    = 6;
  localparam int unsigned BURST_BIT = 5;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned BEAT_BITS = $clog2(BURST_LEN);

endpackage

// File: rtl/mem_cmd_parser.sv
// Byte-stream command parser driving a simple flop-based memory.
// A command byte selects write (bit7), read (bit6) and burst (bit5) with the start address in
// the low ADDR_BITS bits. Writes take one following data byte per beat; reads return one
// response byte per beat through a valid/ready handshake. Commands with bit7 == bit6 pulse err.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_data/valid/ready  host command/data byte stream
//   mem_addr/wdata       memory address and write data
//   mem_wr_en/rd_en      one-cycle memory strobes
//   mem_rdata            memory read data, valid the cycle after mem_rd_en
//   rsp_data/valid/ready read response to host
//   err                  one-cycle pulse on an illegal command
//
// Configuration: define MEM_CMD_BURST_EN to enable 4-beat bursts; otherwise bit5 is ignored and
// no burst counter exists.
module mem_cmd_parser
  import mem_cmd_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 err
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  state_e               r_state;
  logic [ADDR_BITS-1:0] r_addr;      // address of the next beat
  logic                 w_in_fire;
  logic                 w_rsp_fire;
  logic                 w_cmd_wr;
  logic                 w_cmd_rd;
  logic [ADDR_BITS-1:0] w_cmd_addr;
  logic                 w_more;      // further burst beats remain after the current one
  logic                 w_unused_bits;

  assign w_in_fire     = in_valid && in_ready;
  assign w_rsp_fire    = rsp_valid && rsp_ready;
  assign w_cmd_wr      = in_data[WR_BIT];
  assign w_cmd_rd      = in_data[RD_BIT];
  assign w_cmd_addr    = in_data[ADDR_BITS-1:0];
  assign w_unused_bits = ^in_data;

`ifdef MEM_CMD_BURST_EN
  localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);
  localparam logic [BEAT_BITS-1:0] BEAT_INIT = BEAT_BITS'(BURST_LEN - 1);

  logic [BEAT_BITS-1:0] r_beats;     // beats remaining after the current one

  assign w_more = (r_beats != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beats <= '0;
    end else if (r_state == StIdle && w_in_fire) begin
      r_beats <= in_data[BURST_BIT] ? BEAT_INIT : '0;
    end else if (w_more && ((r_state == StWdata && w_in_fire) ||
                            (r_state == StRsp && w_rsp_fire))) begin
      r_beats <= r_beats - BEAT_ONE;
    end
  end
`else
  assign w_more = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      in_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Strobes and err are single-cycle pulses unless re-asserted below.
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      err       <= 1'b0;
      unique case (r_state)
        StIdle: begin
          in_ready <= 1'b1;
          if (w_in_fire) begin
            if (w_cmd_wr && !w_cmd_rd) begin
              r_state <= StWdata;
              r_addr  <= w_cmd_addr;
            end else if (w_cmd_rd && !w_cmd_wr) begin
              // Strobe is issued here so it is visible during the RD_ISSUE cycle.
              r_state   <= StRdIssue;
              in_ready  <= 1'b0;
              mem_rd_en <= 1'b1;
              mem_addr  <= w_cmd_addr;
              r_addr    <= w_cmd_addr + ADDR_ONE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StWdata: begin
          if (w_in_fire) begin
            mem_wr_en <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= in_data;
            r_addr    <= r_addr + ADDR_ONE;
            if (!w_more) r_state <= StIdle;
          end
        end
        StRdIssue: begin
          r_state <= StRdWait;
        end
        StRdWait: begin
          rsp_data  <= mem_rdata;
          rsp_valid <= 1'b1;
          r_state   <= StRsp;
        end
        StRsp: begin
          if (w_rsp_fire) begin
            rsp_valid <= 1'b0;
            if (w_more) begin
              r_state   <= StRdIssue;
              mem_rd_en <= 1'b1;
              mem_addr  <= r_addr;
              r_addr    <= r_addr + ADDR_ONE;
            end else begin
              r_state  <= StIdle;
              in_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_parser.sv
`timescale 1ns/1ps
module tb_mem_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       err;

  int total = 0;
  int bad = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_both = 0;

  logic [7:0] tb_mem [16];

  mem_cmd_parser #(.ADDR_BITS(4), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Flop-based memory: read data appears the cycle after mem_rd_en.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 8'h00;
      tb_mem[3] <= 8'h5A;
      tb_mem[7] <= 8'hC3;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_wr_en) tb_mem[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= tb_mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_wr_en) n_wr++;
    if (mem_rd_en) n_rd++;
    if (mem_wr_en && mem_rd_en) n_both++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and return 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_wait: in_ready=%b required 1 before byte %h", in_ready, b);
    end
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; rsp_ready = 1'b0; in_data = 8'h00;
    tick();
    tick();
    total++;
    if ({in_ready, mem_wr_en, mem_rd_en, rsp_valid, err} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_ctl: got %b required 00000",
               {in_ready, mem_wr_en, mem_rd_en, rsp_valid, err});
    end
    total++;
    if ({mem_addr, mem_wdata, rsp_data} !== 20'h0) begin
      bad++;
      $display("FAIL reset_data: got %h required 00000", {mem_addr, mem_wdata, rsp_data});
    end
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_write();
    int wr0, rd0;
    wr0 = n_wr; rd0 = n_rd;
    send_byte(8'h83);
    total++;
    if ({mem_wr_en, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL write_cmd: wr_en,in_ready=%b required 01", {mem_wr_en, in_ready});
    end
    send_byte(8'h5A);
    total++;
    if ({mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== {2'b10, 4'd3, 8'h5A}) begin
      bad++;
      $display("FAIL write_strobe: wr,rd,addr,data=%b,%b,%0d,%h required 1,0,3,5a",
               mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
    end
    tick();
    total++;
    if (mem_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL write_pulse: wr_en=%b required 0", mem_wr_en);
    end
    total++;
    if (n_wr - wr0 !== 1 || n_rd - rd0 !== 0) begin
      bad++;
      $display("FAIL write_count: writes=%0d reads=%0d required 1 0", n_wr - wr0, n_rd - rd0);
    end
  endtask

  task automatic test_read();
    int wr0, rd0;
    wr0 = n_wr; rd0 = n_rd;
    rsp_ready = 1'b1;
    send_byte(8'h43);
    total++;
    if ({mem_rd_en, mem_wr_en, in_ready, mem_addr} !== {3'b100, 4'd3}) begin
      bad++;
      $display("FAIL read_issue: rd,wr,in_ready,addr=%b,%b,%b,%0d required 1,0,0,3",
               mem_rd_en, mem_wr_en, in_ready, mem_addr);
    end
    tick();
    total++;
    if ({mem_rd_en, rsp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL read_wait: rd,rsp_valid=%b required 00", {mem_rd_en, rsp_valid});
    end
    tick();
    total++;
    if ({rsp_valid, rsp_data} !== {1'b1, 8'h5A}) begin
      bad++;
      $display("FAIL read_rsp: valid,data=%b,%h required 1,5a", rsp_valid, rsp_data);
    end
    tick();
    total++;
    if ({rsp_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL read_done: valid,in_ready=%b required 01", {rsp_valid, in_ready});
    end
    total++;
    if (n_rd - rd0 !== 1 || n_wr - wr0 !== 0) begin
      bad++;
      $display("FAIL read_count: reads=%0d writes=%0d required 1 0", n_rd - rd0, n_wr - wr0);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    send_byte(8'h47);
    tick();
    tick();
    total++;
    if ({rsp_valid, rsp_data, in_ready} !== {1'b1, 8'hC3, 1'b0}) begin
      bad++;
      $display("FAIL bp_first: valid,data,in_ready=%b,%h,%b required 1,c3,0",
               rsp_valid, rsp_data, in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({rsp_valid, rsp_data, in_ready} !== {1'b1, 8'hC3, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d: valid,data,in_ready=%b,%h,%b required 1,c3,0",
                 i, rsp_valid, rsp_data, in_ready);
      end
    end
    rsp_ready = 1'b1;
    tick();
    total++;
    if ({rsp_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: valid,in_ready=%b required 01", {rsp_valid, in_ready});
    end
  endtask

  task automatic test_illegal();
    int wr0, rd0;
    logic [7:0] cmds [2];
    wr0 = n_wr; rd0 = n_rd;
    cmds[0] = 8'hC1;
    cmds[1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      send_byte(cmds[i]);
      total++;
      if ({err, in_ready, mem_wr_en, mem_rd_en} !== 4'b1100) begin
        bad++;
        $display("FAIL illegal_%h: err,in_ready,wr,rd=%b required 1100",
                 cmds[i], {err, in_ready, mem_wr_en, mem_rd_en});
      end
    end
    tick();
    total++;
    if ({err, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL illegal_clear: err,in_ready=%b required 01", {err, in_ready});
    end
    total++;
    if (n_wr - wr0 !== 0 || n_rd - rd0 !== 0) begin
      bad++;
      $display("FAIL illegal_count: writes=%0d reads=%0d required 0 0", n_wr - wr0, n_rd - rd0);
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_wr;
    logic [3:0] exp_addr [4];
    int         exp_n;
    int         wr0;
    logic [7:0] d;
`ifdef MEM_CMD_BURST_EN
    exp_wr = 4'b1111; exp_n = 4;
`else
    exp_wr = 4'b0001; exp_n = 1;
`endif
    exp_addr[0] = 4'd14; exp_addr[1] = 4'd15; exp_addr[2] = 4'd0; exp_addr[3] = 4'd1;
    wr0 = n_wr;
    send_byte(8'hAE);
    for (int i = 0; i < 4; i++) begin
      d = 8'(i + 1);
      send_byte(d);
      total++;
      if ({mem_wr_en, err} !== {exp_wr[i], ~exp_wr[i]}) begin
        bad++;
        $display("FAIL burst_beat%0d: wr,err=%b,%b required %b,%b",
                 i, mem_wr_en, err, exp_wr[i], ~exp_wr[i]);
      end else if (exp_wr[i] && {mem_addr, mem_wdata} !== {exp_addr[i], d}) begin
        bad++;
        $display("FAIL burst_addr%0d: addr,data=%0d,%h required %0d,%h",
                 i, mem_addr, mem_wdata, exp_addr[i], d);
      end
    end
    tick();
    total++;
    if ({in_ready, mem_wr_en} !== 2'b10 || n_wr - wr0 !== exp_n) begin
      bad++;
      $display("FAIL burst_end: in_ready,wr=%b writes=%0d required 10 writes=%0d",
               {in_ready, mem_wr_en}, n_wr - wr0, exp_n);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    send_byte(8'h82);
    send_byte(8'h11);
    total++;
    if ({mem_wr_en, mem_addr, mem_wdata, in_ready} !== {1'b1, 4'd2, 8'h11, 1'b1}) begin
      bad++;
      $display("FAIL b2b_write: wr,addr,data,in_ready=%b,%0d,%h,%b required 1,2,11,1",
               mem_wr_en, mem_addr, mem_wdata, in_ready);
    end
    send_byte(8'h42);
    total++;
    if ({mem_rd_en, mem_wr_en, mem_addr} !== {2'b10, 4'd2}) begin
      bad++;
      $display("FAIL b2b_issue: rd,wr,addr=%b,%b,%0d required 1,0,2",
               mem_rd_en, mem_wr_en, mem_addr);
    end
    tick();
    tick();
    total++;
    if ({rsp_valid, rsp_data} !== {1'b1, 8'h11}) begin
      bad++;
      $display("FAIL b2b_rsp: valid,data=%b,%h required 1,11", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int wr0;
    wr0 = n_wr;
    send_byte(8'h85);
    rst = 1'b1; in_data = 8'h3C; in_valid = 1'b1;
    tick();
    total++;
    if ({in_ready, mem_wr_en, mem_rd_en, rsp_valid, err, mem_addr, mem_wdata, rsp_data}
        !== 25'h0) begin
      bad++;
      $display("FAIL mid_reset: ctl=%b addr=%0d wdata=%h rsp=%h required all 0",
               {in_ready, mem_wr_en, mem_rd_en, rsp_valid, err}, mem_addr, mem_wdata, rsp_data);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    total++;
    if ({in_ready, mem_wr_en} !== 2'b10) begin
      bad++;
      $display("FAIL mid_ready: in_ready,wr=%b required 10", {in_ready, mem_wr_en});
    end
    // The abandoned data byte must now decode as a command (illegal), not as write data.
    send_byte(8'h3C);
    total++;
    if ({err, mem_wr_en} !== 2'b10) begin
      bad++;
      $display("FAIL mid_discard: err,wr=%b required 10", {err, mem_wr_en});
    end
    tick();
    total++;
    if (n_wr - wr0 !== 0) begin
      bad++;
      $display("FAIL mid_count: writes=%0d required 0", n_wr - wr0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_illegal();
    test_burst();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (n_both !== 0) begin
      bad++;
      $display("FAIL strobe_overlap: cycles=%0d required 0", n_both);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_cmd_parser.md
MEM_CMD_PARSER -- requirements
Module: mem_cmd_parser

Interface
REQ-001 Parameter: ADDR_BITS, default 4, memory address width.
REQ-002 Parameter: DATA_BITS, default 8, byte width of stream, memory data and response.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  DATA_BITS  command/data byte stream from host.
REQ-006 in_valid  input  1  in_data valid; byte accepted when in_valid && in_ready at a rising edge.
REQ-007 in_ready  output  1  parser can accept a byte.
REQ-008 mem_addr  output  ADDR_BITS  address to the downstream dff memory.
REQ-009 mem_wdata  output  DATA_BITS  write data to memory.
REQ-010 mem_wr_en / mem_rd_en  output  1 each  one-cycle write/read strobes to memory.
REQ-011 mem_rdata  input  DATA_BITS  memory read data, valid the cycle after mem_rd_en.
REQ-012 rsp_data  output  DATA_BITS  read result to host; rsp_valid output 1; rsp_ready input 1; transfer on rsp_valid && rsp_ready.
REQ-013 err  output  1  one-cycle pulse on illegal command.

Function
REQ-014 Command byte: bit7 = write, bit6 = read, bit5 = burst, bits[ADDR_BITS-1:0] = start address; other bits ignored.
REQ-015 States: IDLE, WDATA, RD_ISSUE, RD_WAIT, RSP; in_ready = 1 only in IDLE and WDATA.
REQ-016 IDLE: write-only command accepted -> WDATA; read-only command -> RD_ISSUE; bit7 == bit6 -> err pulses next cycle, stay IDLE, no memory strobe.
REQ-017 WDATA: data byte accepted at edge N -> mem_wr_en = 1, mem_addr, mem_wdata stable during cycle N+1 only; then IDLE (or WDATA for next burst beat).
REQ-018 RD_ISSUE: mem_rd_en = 1 for exactly one cycle with mem_addr; next RD_WAIT, where mem_rdata is captured into rsp_data at the end of the cycle; next RSP.
REQ-019 Read latency: command accepted at edge N -> rsp_valid first high in cycle N+3.
REQ-020 RSP: rsp_valid and rsp_data held stable until rsp_ready; on handshake go to IDLE (or RD_ISSUE for next burst beat); rsp_valid drops the following cycle.
REQ-021 All outputs registered; mem_wr_en and mem_rd_en never high in the same cycle; mem strobes low in every state not named above.
REQ-022 in_valid low in WDATA: wait indefinitely, no timeout.
REQ-023 Address arithmetic modulo 2**ADDR_BITS (15 + 1 -> 0).

Reset
REQ-024 rst high at an edge: state IDLE, in_ready 0, mem_wr_en 0, mem_rd_en 0, rsp_valid 0, err 0, mem_addr 0, mem_wdata 0, rsp_data 0, burst count 0.
REQ-025 in_ready = 1 in the first cycle after rst deasserts.
REQ-026 rst mid-operation aborts any pending write, read, burst or response; partial data is discarded, never written.

Configuration
REQ-027 Macro MEM_CMD_BURST_EN defined: bit5 = 1 repeats the operation for 4 beats at start, start+1, start+2, start+3 (wrapping); each write beat takes one data byte; each read beat produces one response.
REQ-028 MEM_CMD_BURST_EN undefined: bit5 ignored, every command is single-beat, no burst counter is synthesised.

Structure
REQ-029 Shared package mem_cmd_pkg holds the state enum, command bit positions (WR_BIT 7, RD_BIT 6, BURST_BIT 5) and BURST_LEN = 4.
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 Write: cmd 0x83, data 0x5A -> mem_wr_en for one cycle with mem_addr 3, mem_wdata 0x5A; no mem_rd_en.
REQ-032 Read: cmd 0x43, mem_rdata 0x5A, rsp_ready held 1 -> mem_rd_en addr 3 one cycle after accept; rsp_valid with 0x5A three cycles after accept, for one cycle.
REQ-033 Backpressure: read with rsp_ready 0 for 10 cycles -> rsp_valid and rsp_data stable, in_ready 0 throughout; clears one cycle after rsp_ready.
REQ-034 Illegal: cmd 0xC1 then 0x01 -> err one-cycle pulse each time, no memory strobe, in_ready remains 1.
REQ-035 Burst (MEM_CMD_BURST_EN): cmd 0xAE, data 1,2,3,4 -> writes to addresses 14, 15, 0, 1; without macro, the same stream writes 1 to address 14 and reports byte 2 as a command (err pulse).
REQ-036 Reset: rst after the write command but before its data byte -> no mem_wr_en, all outputs 0, in_ready 1 the cycle after rst drops.
